instruction_fetch_stage: RTL and testbench

- Fetch stage upstream of the main control decoder.
- Holds the PC and issues word reads to instruction memory over a req/valid handshake.
- Registers the returned instruction and presents it to decode with a valid/stall handshake.
- Drives opcode[5:0] straight into the control unit's OP input; accepts branch/jump redirects from the execute side.

---
 rtl/instruction_fetch_stage.sv | 161 ++++++++++++++++
 tb/tb_instruction_fetch_stage.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_stage.sv
// Instruction fetch stage: holds the PC, issues word reads to instruction
// memory over a req/valid handshake, and presents the fetched instruction to
// decode with a valid/stall handshake. Execute-side redirects override
// everything else.
// Optional feature: define MISALIGN_TRAP_EN to trap on redirects whose
// target is not word aligned. When it is undefined, redirect_pc[1:0] is
// forced to 2'b00 and misaligned stays 0.
module instruction_fetch_stage #(
    parameter int unsigned           ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] PC_RESET   = 32'h0040_0000
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic                  imem_req,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic                  imem_valid,
    input  logic [31:0]           imem_rdata,
    input  logic                  stall,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic                  instr_valid,
    output logic [31:0]           instr,
    output logic [5:0]            opcode,
    output logic [ADDR_WIDTH-1:0] instr_pc,
    output logic [ADDR_WIDTH-1:0] pc_plus4,
    output logic                  misaligned
);

    typedef enum logic [2:0] {IDLE, FETCH, HOLD, DRAIN, TRAP} state_t;

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_pc;
    logic [ADDR_WIDTH-1:0] r_imem_addr;
    logic [ADDR_WIDTH-1:0] r_instr_pc;
    logic [31:0]           r_instr;
    logic                  r_imem_req;
    logic                  r_instr_valid;
    logic                  r_misaligned;

    logic [ADDR_WIDTH-1:0] w_redir_pc;
    logic                  w_redir_bad;
    logic                  w_trap_next;

`ifdef MISALIGN_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
    assign w_redir_pc = redirect_pc;
`else
    localparam bit TRAP_EN = 1'b0;
    assign w_redir_pc = {redirect_pc[ADDR_WIDTH-1:2], 2'b00};
`endif

    // A misaligned target only matters when the trap is built in; once seen,
    // the trap stays pending until the outstanding read (if any) has drained.
    assign w_redir_bad = TRAP_EN & (|redirect_pc[1:0]);
    assign w_trap_next = w_redir_bad | r_misaligned;

    assign imem_req    = r_imem_req;
    assign imem_addr   = r_imem_addr;
    assign instr_valid = r_instr_valid;
    assign instr       = r_instr;
    assign instr_pc    = r_instr_pc;
    assign opcode      = r_instr[31:26];
    assign pc_plus4    = r_instr_pc + ADDR_WIDTH'(4);
    assign misaligned  = r_misaligned;

    // Fetch FSM: PC, memory request and decode-side instruction register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= IDLE;
            r_pc          <= PC_RESET;
            r_imem_req    <= 1'b0;
            r_imem_addr   <= PC_RESET;
            r_instr_valid <= 1'b0;
            r_instr       <= '0;
            r_instr_pc    <= '0;
            r_misaligned  <= 1'b0;
        end else if (redirect_valid && r_state != TRAP) begin
            r_pc          <= w_redir_pc;
            r_instr_valid <= 1'b0;
            if (w_redir_bad) begin
                r_misaligned <= 1'b1;
            end
            case (r_state)
                // A read is outstanding: if it completes on this edge its data
                // is dropped and the new address goes out at once (this also
                // covers DRAIN, so a redirect there cannot strand the FSM);
                // otherwise keep the old request up and wait in DRAIN.
                FETCH, DRAIN: begin
                    if (imem_valid) begin
                        if (w_trap_next) begin
                            r_state    <= TRAP;
                            r_imem_req <= 1'b0;
                        end else begin
                            r_state     <= FETCH;
                            r_imem_req  <= 1'b1;
                            r_imem_addr <= w_redir_pc;
                        end
                    end else begin
                        r_state <= DRAIN;
                    end
                end
                default: begin
                    if (w_trap_next) begin
                        r_state    <= TRAP;
                        r_imem_req <= 1'b0;
                    end else begin
                        r_state     <= FETCH;
                        r_imem_req  <= 1'b1;
                        r_imem_addr <= w_redir_pc;
                    end
                end
            endcase
        end else begin
            case (r_state)
                IDLE: begin
                    r_state     <= FETCH;
                    r_imem_req  <= 1'b1;
                    r_imem_addr <= r_pc;
                end
                FETCH: begin
                    if (imem_valid) begin
                        r_instr       <= imem_rdata;
                        r_instr_pc    <= r_pc;
                        r_instr_valid <= 1'b1;
                        r_pc          <= r_pc + ADDR_WIDTH'(4);
                        r_imem_req    <= 1'b0;
                        r_state       <= HOLD;
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        r_instr_valid <= 1'b0;
                        r_imem_req    <= 1'b1;
                        r_imem_addr   <= r_pc;
                        r_state       <= FETCH;
                    end
                end
                DRAIN: begin
                    if (imem_valid) begin
                        if (r_misaligned) begin
                            r_state    <= TRAP;
                            r_imem_req <= 1'b0;
                        end else begin
                            r_state     <= FETCH;
                            r_imem_req  <= 1'b1;
                            r_imem_addr <= r_pc;
                        end
                    end
                end
                TRAP: begin
                    r_imem_req    <= 1'b0;
                    r_instr_valid <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Self-checking bench for instruction_fetch_stage: a behavioural instruction
// memory with programmable latency, an expected-address queue checked when
// the memory accepts a request, and an expected-instruction queue checked
// when decode sees a new valid instruction.
module tb_instruction_fetch_stage;

    localparam logic [31:0] PC_RESET = 32'h0040_0000;

    logic        clk;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_valid;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic [31:0] instr;
    logic [5:0]  opcode;
    logic [31:0] instr_pc;
    logic [31:0] pc_plus4;
    logic        misaligned;

    int unsigned n_cmp   = 0;
    int unsigned n_bad   = 0;
    int unsigned lat     = 1;
    int unsigned n_instr = 0;
    int unsigned cyc     = 0;
    logic [31:0] exp_addr_q[$];
    logic [31:0] exp_pc_q[$];
    int unsigned stamp_q[$];

    instruction_fetch_stage #(
        .ADDR_WIDTH(32),
        .PC_RESET  (PC_RESET)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_valid    (imem_valid),
        .imem_rdata    (imem_rdata),
        .stall         (stall),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .instr_valid   (instr_valid),
        .instr         (instr),
        .opcode        (opcode),
        .instr_pc      (instr_pc),
        .pc_plus4      (pc_plus4),
        .misaligned    (misaligned)
    );

    function automatic logic [31:0] word(input logic [31:0] a);
        return a ^ 32'h2048_000A;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    // Instruction memory: accepts one request at a time, answers after lat edges.
    initial begin
        logic        busy;
        int unsigned cnt;
        logic [31:0] maddr;
        busy = 1'b0;
        cnt = 0;
        maddr = '0;
        imem_valid = 1'b0;
        imem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            imem_valid = 1'b0;
            if (!reset) begin
                busy = 1'b0;
            end else begin
                if (!busy && imem_req) begin
                    if (exp_addr_q.size() == 0)
                        check("sb_addr_depth", 32'(exp_addr_q.size()), 32'd1);
                    else
                        check("imem_addr", imem_addr, exp_addr_q.pop_front());
                    maddr = imem_addr;
                    busy = 1'b1;
                    cnt = lat;
                end
                if (busy) begin
                    cnt--;
                    if (cnt == 0) begin
                        imem_valid = 1'b1;
                        imem_rdata = word(maddr);
                        busy = 1'b0;
                    end
                end
            end
        end
    end

    // Decode-side monitor: every new valid instruction is matched against the queue.
    initial begin
        logic        prev;
        logic [31:0] e;
        logic [31:0] w;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (instr_valid && !prev) begin
                n_instr++;
                stamp_q.push_back(cyc);
                if (exp_pc_q.size() == 0) begin
                    check("sb_instr_depth", 32'(exp_pc_q.size()), 32'd1);
                end else begin
                    e = exp_pc_q.pop_front();
                    w = word(e);
                    check("instr_pc", instr_pc, e);
                    check("instr", instr, w);
                    check("opcode", {26'd0, opcode}, {26'd0, w[31:26]});
                    check("pc_plus4", pc_plus4, e + 32'd4);
                end
            end
            prev = instr_valid;
        end
    end

    task automatic drain(input string tag);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            #1;
            if (exp_addr_q.size() == 0 && exp_pc_q.size() == 0) break;
        end
        repeat (3) @(negedge clk);
        #1;
        check(tag, 32'(exp_addr_q.size() + exp_pc_q.size()), 32'd0);
    endtask

    task automatic run_until(input int unsigned target);
        for (int i = 0; i < 100; i++) begin
            if (n_instr >= target) break;
            @(negedge clk);
            #1;
        end
        check("instr_count", n_instr, target);
    endtask

    task automatic fetch_one();
        stall = 1'b0;
        @(posedge clk);
        #2;
        stall = 1'b1;
    endtask

    task automatic expect_fetch(input logic [31:0] a, input bit delivered);
        exp_addr_q.push_back(a);
        if (delivered) exp_pc_q.push_back(a);
    endtask

    initial begin
        logic [31:0] w8;
        reset = 1'b1;
        stall = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        #1;
        reset = 1'b0;
        #1;
        check("rst_req", 32'(imem_req), 32'd0);
        check("rst_addr", imem_addr, PC_RESET);
        check("rst_valid", 32'(instr_valid), 32'd0);
        check("rst_instr", instr, 32'd0);
        check("rst_instr_pc", instr_pc, 32'd0);
        check("rst_misaligned", 32'(misaligned), 32'd0);

        // Streaming fetch, latency 1, no stall.
        expect_fetch(32'h0040_0000, 1);
        expect_fetch(32'h0040_0004, 1);
        expect_fetch(32'h0040_0008, 1);
        repeat (2) @(negedge clk);
        #1;
        reset = 1'b1;
        run_until(1);
        check("opcode_first", {26'd0, opcode}, 32'h0000_0008);
        run_until(3);
        stall = 1'b1;
        drain("t1_drain");
        check("t1_gap_a", stamp_q[1] - stamp_q[0], 32'd2);
        check("t1_gap_b", stamp_q[2] - stamp_q[1], 32'd2);

        // Stall held in HOLD, then resume.
        w8 = word(32'h0040_0008);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            check("t2_hold_pc", instr_pc, 32'h0040_0008);
            check("t2_hold_instr", instr, w8);
            check("t2_hold_valid", 32'(instr_valid), 32'd1);
            check("t2_no_req", 32'(imem_req), 32'd0);
        end
        expect_fetch(32'h0040_000C, 1);
        stall = 1'b0;
        @(negedge clk);
        #1;
        check("t2_resume_req", 32'(imem_req), 32'd1);
        check("t2_resume_addr", imem_addr, 32'h0040_000C);
        stall = 1'b1;
        drain("t2_drain");

        // Redirect while a latency-4 read is outstanding.
        lat = 4;
        expect_fetch(32'h0040_0010, 0);
        expect_fetch(32'h0040_0100, 1);
        stall = 1'b0;
        @(posedge clk);
        #2;
        stall = 1'b1;
        @(posedge clk);
        #2;
        redirect_valid = 1'b1;
        redirect_pc = 32'h0040_0100;
        @(posedge clk);
        #2;
        redirect_valid = 1'b0;
        check("t3_old_req_held", 32'(imem_req), 32'd1);
        check("t3_old_addr_held", imem_addr, 32'h0040_0010);
        check("t3_valid_low", 32'(instr_valid), 32'd0);
        drain("t3_drain");

        // Redirect on the same edge as imem_valid.
        lat = 2;
        expect_fetch(32'h0040_0104, 0);
        expect_fetch(32'h0040_0200, 1);
        stall = 1'b0;
        @(posedge clk);
        #2;
        stall = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (imem_valid) break;
            @(posedge clk);
            #2;
        end
        check("t4_valid_seen", 32'(imem_valid), 32'd1);
        redirect_valid = 1'b1;
        redirect_pc = 32'h0040_0200;
        @(posedge clk);
        #2;
        redirect_valid = 1'b0;
        drain("t4_drain");

        // PC wrap at the top of the address space.
        lat = 1;
        expect_fetch(32'hFFFF_FFFC, 1);
        redirect_valid = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        @(posedge clk);
        #2;
        redirect_valid = 1'b0;
        drain("t5_drain");
        check("t5_instr_pc", instr_pc, 32'hFFFF_FFFC);
        check("t5_plus4_wrap", pc_plus4, 32'h0000_0000);
        expect_fetch(32'h0000_0000, 1);
        fetch_one();
        drain("t5b_drain");

        // Asynchronous reset in the middle of an outstanding read.
        lat = 4;
        expect_fetch(32'h0000_0004, 0);
        fetch_one();
        @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        check("t6_req", 32'(imem_req), 32'd0);
        check("t6_valid", 32'(instr_valid), 32'd0);
        check("t6_addr", imem_addr, PC_RESET);
        check("t6_instr_pc", instr_pc, 32'd0);
        expect_fetch(32'h0040_0000, 1);
        repeat (2) @(negedge clk);
        #1;
        reset = 1'b1;
        drain("t6_drain");

        // Misaligned redirect target.
`ifdef MISALIGN_TRAP_EN
        redirect_valid = 1'b1;
        redirect_pc = 32'h0040_0102;
        stall = 1'b0;
        @(posedge clk);
        #2;
        redirect_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            #1;
            check("t7_misaligned", 32'(misaligned), 32'd1);
            check("t7_no_req", 32'(imem_req), 32'd0);
            check("t7_no_valid", 32'(instr_valid), 32'd0);
        end
`else
        lat = 1;
        expect_fetch(32'h0040_0100, 1);
        redirect_valid = 1'b1;
        redirect_pc = 32'h0040_0102;
        @(posedge clk);
        #2;
        redirect_valid = 1'b0;
        drain("t7_drain");
        check("t7_misaligned", 32'(misaligned), 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
